// File: rtl/effects_to_dac_spi.sv
// effects_to_dac_spi: output sink of the effects chain. Buffers one 12-bit
// sample and shifts it out as a 16-bit DAC121S101 SPI frame, MSB first.
// Ports: clk, rst (sync, active high); s_data/s_valid/s_ready sample
// handshake; dac_sclk/dac_sync_n/dac_din to the DAC; busy and frame_done.
module effects_to_dac_spi #(
  parameter int CLK_DIV   = 4,
  parameter bit SIGNED_IN = 1'b0,
  parameter int GAP_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        busy,
  output logic        frame_done
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [15:0]   shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sclk_d, sync_d, din_d;
  logic          ready_d, busy_d, done_d;
  logic [11:0]   conv;
  logic          accept;
  logic          div_tc;

  // Offset binary for the DAC: flipping the sign bit maps -2048..2047
  // onto 0..4095.
  assign conv   = SIGNED_IN ? {~s_data[11], s_data[10:0]} : s_data;
  assign accept = s_valid && s_ready;
  assign div_tc = (div_q == 8'(CLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    div_d       = div_q;
    gap_d       = gap_q;
    sclk_d      = dac_sclk;
    sync_d      = dac_sync_n;
    din_d       = dac_din;
    done_d      = 1'b0;

    // accept needs an empty hold, the IDLE transfer needs a full one,
    // so the two never collide on hold_full.
    if (accept) begin
      hold_d      = conv;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = LOAD;
          shift_d     = {4'b0000, hold_q};
          hold_full_d = 1'b0;
          sync_d      = 1'b0;
          sclk_d      = 1'b1;
          din_d       = 1'b0;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        bit_d   = 4'd15;
        div_d   = '0;
      end
      SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_tc) begin
          div_d  = '0;
          sclk_d = ~dac_sclk;
          // Data only moves on rising sclk; the DAC samples on falling.
          if (!dac_sclk) begin
            if (bit_q == 4'd0) begin
              state_d = GAP;
              sync_d  = 1'b1;
              done_d  = 1'b1;
              din_d   = 1'b0;
              gap_d   = '0;
            end else begin
              bit_d = bit_q - 4'd1;
              din_d = shift_q[bit_q - 4'd1];
            end
          end
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = !hold_full_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      s_ready     <= 1'b1;
      dac_sclk    <= 1'b1;
      dac_sync_n  <= 1'b1;
      dac_din     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      s_ready     <= ready_d;
      dac_sclk    <= sclk_d;
      dac_sync_n  <= sync_d;
      dac_din     <= din_d;
      busy        <= busy_d;
      frame_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_effects_to_dac_spi.sv
// tb_effects_to_dac_spi: bench for effects_to_dac_spi over four parameter
// sets, with an SPI monitor that rebuilds frames from the DAC pins.
module tb_effects_to_dac_spi;

  localparam int N     = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] s_data  [N];
  logic        s_valid [N];
  logic        s_ready [N];
  logic        sclk    [N];
  logic        sync_n  [N];
  logic        din     [N];
  logic        busy    [N];
  logic        fd      [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  effects_to_dac_spi u0 (
    .clk(clk), .rst(rst),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .dac_sclk(sclk[0]), .dac_sync_n(sync_n[0]), .dac_din(din[0]),
    .busy(busy[0]), .frame_done(fd[0])
  );

  effects_to_dac_spi #(.SIGNED_IN(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .dac_sclk(sclk[1]), .dac_sync_n(sync_n[1]), .dac_din(din[1]),
    .busy(busy[1]), .frame_done(fd[1])
  );

  effects_to_dac_spi #(.CLK_DIV(2), .GAP_CYC(3)) u2 (
    .clk(clk), .rst(rst),
    .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .dac_sclk(sclk[2]), .dac_sync_n(sync_n[2]), .dac_din(din[2]),
    .busy(busy[2]), .frame_done(fd[2])
  );

  effects_to_dac_spi #(.CLK_DIV(9), .GAP_CYC(1)) u3 (
    .clk(clk), .rst(rst),
    .s_data(s_data[3]), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
    .dac_sclk(sclk[3]), .dac_sync_n(sync_n[3]), .dac_din(din[3]),
    .busy(busy[3]), .frame_done(fd[3])
  );

  function automatic int cdiv(int i);
    case (i)
      2: return 2;
      3: return 9;
      default: return 4;
    endcase
  endfunction

  function automatic int gapc(int i);
    case (i)
      2: return 3;
      3: return 1;
      default: return 8;
    endcase
  endfunction

  // Frame the DAC should see: 4 zero control bits, then the code, with
  // signed input shifted up by 2048 into the unsigned DAC range.
  function automatic logic [15:0] model(int i, logic [11:0] d);
    int v;
    v = int'(d);
    if (i == 1) begin
      if (v >= 2048) v = v - 4096;
      v = v + 2048;
    end
    return 16'(v);
  endfunction

  logic [15:0] cap_frame [N][DEPTH];
  int          cap_low   [N][DEPTH];
  int          cap_falls [N][DEPTH];
  int          cap_hmin  [N][DEPTH];
  int          cap_hmax  [N][DEPTH];
  logic        cap_fd    [N][DEPTH];
  int          cap_gap   [N][DEPTH];
  int          cap_n     [N] = '{default: 0};
  int          gap_n     [N] = '{default: 0};
  int          done_cyc  [N] = '{default: 0};
  int          fd_cnt    [N] = '{default: 0};
  int          fd_wide   [N] = '{default: 0};
  logic [15:0] m_word    [N] = '{default: 16'h0};
  int          m_low     [N] = '{default: 0};
  int          m_falls   [N] = '{default: 0};
  int          m_hi      [N] = '{default: 0};
  int          m_ntog    [N] = '{default: 0};
  int          m_last    [N] = '{default: 0};
  int          m_hmin    [N] = '{default: 1000};
  int          m_hmax    [N] = '{default: 0};
  logic        p_sclk    [N] = '{default: 1'b1};
  logic        p_sync    [N] = '{default: 1'b1};
  logic        p_fd      [N] = '{default: 1'b0};

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        int k;
        int h;
        if (rst) begin
          m_word[i]  = '0;
          m_low[i]   = 0;
          m_falls[i] = 0;
          m_ntog[i]  = 0;
          m_hmin[i]  = 1000;
          m_hmax[i]  = 0;
        end
        if (sclk[i] !== p_sclk[i]) begin
          if (m_ntog[i] > 0) begin
            h = cyc - m_last[i];
            if (h < m_hmin[i]) m_hmin[i] = h;
            if (h > m_hmax[i]) m_hmax[i] = h;
          end
          m_last[i] = cyc;
          m_ntog[i]++;
          if (p_sclk[i] === 1'b1 && sclk[i] === 1'b0 && sync_n[i] === 1'b0) begin
            m_word[i] = {m_word[i][14:0], din[i]};
            m_falls[i]++;
          end
        end
        if (p_sync[i] === 1'b1 && sync_n[i] === 1'b0) begin
          cap_gap[i][gap_n[i] % DEPTH] = m_hi[i];
          gap_n[i]++;
        end
        if (sync_n[i] === 1'b0) m_low[i]++;
        if (p_sync[i] === 1'b0 && sync_n[i] === 1'b1) begin
          k = cap_n[i] % DEPTH;
          cap_frame[i][k] = m_word[i];
          cap_low[i][k]   = m_low[i];
          cap_falls[i][k] = m_falls[i];
          cap_hmin[i][k]  = m_hmin[i];
          cap_hmax[i][k]  = m_hmax[i];
          cap_fd[i][k]    = fd[i];
          cap_n[i]++;
          done_cyc[i] = cyc;
          m_word[i]  = '0;
          m_low[i]   = 0;
          m_falls[i] = 0;
          m_ntog[i]  = 0;
          m_hmin[i]  = 1000;
          m_hmax[i]  = 0;
          m_hi[i]    = 0;
        end
        if (sync_n[i] === 1'b1) m_hi[i]++;
        if (fd[i] === 1'b1 && p_fd[i] === 1'b1) fd_wide[i]++;
        if (fd[i] === 1'b1 && p_fd[i] !== 1'b1) fd_cnt[i]++;
        p_sclk[i] = sclk[i];
        p_sync[i] = sync_n[i];
        p_fd[i]   = fd[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [11:0] d);
    int n;
    n = 0;
    s_data[i]  = d;
    s_valid[i] = 1'b1;
    while (s_ready[i] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (s_ready[i] !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout inst=%0d got ready=%b want 1", i, s_ready[i]);
    end else begin
      tick();
    end
    s_valid[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int target);
    int n;
    n = 0;
    while (cap_n[i] < target && n < 3000) begin
      tick();
      n++;
    end
    total++;
    if (cap_n[i] < target) begin
      bad++;
      $display("FAIL frame_timeout inst=%0d got=%0d want=%0d", i, cap_n[i], target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      logic [5:0] got;
      got = {s_ready[i], sclk[i], sync_n[i], din[i], busy[i], fd[i]};
      total++;
      if (got !== 6'b111000) begin
        bad++;
        $display("FAIL reset_state inst=%0d got=%b want=111000", i, got);
      end
    end
  endtask

  task automatic test_single();
    int base, f0, w0, k, n;
    base = cap_n[0];
    f0   = fd_cnt[0];
    w0   = fd_wide[0];
    send(0, 12'hA5C);
    wait_frames(0, base + 1);
    k = base % DEPTH;
    total++;
    if (cap_frame[0][k] !== 16'h0A5C) begin
      bad++;
      $display("FAIL single_frame got=%h want=0a5c", cap_frame[0][k]);
    end
    total++;
    if (cap_low[0][k] !== 129) begin
      bad++;
      $display("FAIL single_sync_low got=%0d want=129", cap_low[0][k]);
    end
    total++;
    if (cap_falls[0][k] !== 16) begin
      bad++;
      $display("FAIL single_falls got=%0d want=16", cap_falls[0][k]);
    end
    total++;
    if (cap_fd[0][k] !== 1'b1) begin
      bad++;
      $display("FAIL single_done_at_end got=%b want=1", cap_fd[0][k]);
    end
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (cyc - done_cyc[0] !== gapc(0)) begin
      bad++;
      $display("FAIL single_busy_tail got=%0d want=%0d", cyc - done_cyc[0], gapc(0));
    end
    repeat (300) tick();
    total++;
    if (cap_n[0] !== base + 1 || sync_n[0] !== 1'b1 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_no_underrun got frames=%0d sync_n=%b busy=%b want %0d 1 0",
               cap_n[0] - base, sync_n[0], busy[0], 1);
    end
    total++;
    if (fd_cnt[0] - f0 !== 1 || fd_wide[0] !== w0) begin
      bad++;
      $display("FAIL single_done_pulse got pulses=%0d wide=%0d want 1 0",
               fd_cnt[0] - f0, fd_wide[0] - w0);
    end
  endtask

  task automatic test_signed();
    logic [11:0] din_v [2];
    logic [15:0] want  [2];
    int base;
    din_v[0] = 12'h800;
    want[0]  = 16'h0000;
    din_v[1] = 12'h7FF;
    want[1]  = 16'h0FFF;
    for (int j = 0; j < 2; j++) begin
      base = cap_n[1];
      send(1, din_v[j]);
      wait_frames(1, base + 1);
      total++;
      if (cap_frame[1][base % DEPTH] !== want[j]) begin
        bad++;
        $display("FAIL signed_frame in=%h got=%h want=%h",
                 din_v[j], cap_frame[1][base % DEPTH], want[j]);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      int i, base, k;
      logic [11:0] d;
      i = j % N;
      d = 12'($urandom);
      base = cap_n[i];
      send(i, d);
      wait_frames(i, base + 1);
      k = base % DEPTH;
      total++;
      if (cap_frame[i][k] !== model(i, d) ||
          cap_low[i][k] !== 32 * cdiv(i) + 1 ||
          cap_falls[i][k] !== 16) begin
        bad++;
        $display("FAIL random_frame inst=%0d in=%h got=%h/%0d/%0d want=%h/%0d/16",
                 i, d, cap_frame[i][k], cap_low[i][k], cap_falls[i][k],
                 model(i, d), 32 * cdiv(i) + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, gbase, sent, n;
    logic acc;
    base  = cap_n[0];
    gbase = gap_n[0];
    sent  = 0;
    n     = 0;
    s_data[0]  = 12'd0;
    s_valid[0] = 1'b1;
    while (sent < 5 && n < 3000) begin
      acc = s_ready[0];
      tick();
      n++;
      if (acc === 1'b1) begin
        sent++;
        s_data[0] = 12'(sent);
        total++;
        if (s_ready[0] !== 1'b0) begin
          bad++;
          $display("FAIL b2b_ready_low sample=%0d got=%b want=0", sent - 1, s_ready[0]);
        end
      end
    end
    s_valid[0] = 1'b0;
    total++;
    if (sent != 5) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d want=5", sent);
    end
    wait_frames(0, base + 5);
    repeat (300) tick();
    total++;
    if (cap_n[0] - base !== 5) begin
      bad++;
      $display("FAIL b2b_frame_count got=%0d want=5", cap_n[0] - base);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (cap_frame[0][(base + k) % DEPTH] !== model(0, 12'(k))) begin
        bad++;
        $display("FAIL b2b_frame idx=%0d got=%h want=%h",
                 k, cap_frame[0][(base + k) % DEPTH], model(0, 12'(k)));
      end
    end
    for (int k = 1; k < 5; k++) begin
      total++;
      if (cap_gap[0][(gbase + k) % DEPTH] !== gapc(0) + 1) begin
        bad++;
        $display("FAIL b2b_gap idx=%0d got=%0d want=%0d",
                 k, cap_gap[0][(gbase + k) % DEPTH], gapc(0) + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, base2;
    logic [4:0] got;
    send(0, 12'($urandom));
    send(0, 12'($urandom));
    n = 0;
    while (m_falls[0] < 7 && n < 2000) begin
      tick();
      n++;
    end
    total++;
    if (m_falls[0] != 7) begin
      bad++;
      $display("FAIL midrst_reach got=%0d want=7 falls", m_falls[0]);
    end
    rst = 1'b1;
    tick();
    got = {sync_n[0], sclk[0], din[0], busy[0], s_ready[0]};
    total++;
    if (got !== 5'b11001) begin
      bad++;
      $display("FAIL midrst_outputs got=%b want=11001", got);
    end
    rst = 1'b0;
    base2 = cap_n[0];
    repeat (400) tick();
    total++;
    if (cap_n[0] !== base2) begin
      bad++;
      $display("FAIL midrst_hold_dropped got=%0d want=0 frames", cap_n[0] - base2);
    end
    send(0, 12'h123);
    wait_frames(0, base2 + 1);
    total++;
    if (cap_frame[0][base2 % DEPTH] !== 16'h0123 ||
        cap_falls[0][base2 % DEPTH] !== 16) begin
      bad++;
      $display("FAIL midrst_clean_frame got=%h/%0d want=0123/16",
               cap_frame[0][base2 % DEPTH], cap_falls[0][base2 % DEPTH]);
    end
  endtask

  task automatic test_divider();
    for (int i = 2; i < 4; i++) begin
      int base, k;
      base = cap_n[i];
      send(i, 12'hFFF);
      wait_frames(i, base + 1);
      k = base % DEPTH;
      total++;
      if (cap_frame[i][k] !== 16'h0FFF) begin
        bad++;
        $display("FAIL div_frame inst=%0d got=%h want=0fff", i, cap_frame[i][k]);
      end
      total++;
      if (cap_hmin[i][k] !== cdiv(i) || cap_hmax[i][k] !== cdiv(i)) begin
        bad++;
        $display("FAIL div_half_period inst=%0d got=%0d..%0d want=%0d",
                 i, cap_hmin[i][k], cap_hmax[i][k], cdiv(i));
      end
      total++;
      if (cap_low[i][k] !== 32 * cdiv(i) + 1) begin
        bad++;
        $display("FAIL div_sync_low inst=%0d got=%0d want=%0d",
                 i, cap_low[i][k], 32 * cdiv(i) + 1);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      s_data[i]  = 12'h000;
      s_valid[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_signed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_divider();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
